// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port among
// NREQ writeback requesters, with a one-stage registered output and dest filtering.
module reg_wr_arbiter #(
    parameter int NREQ   = 3,
    parameter int AW     = 5,
    parameter int DW     = 32,
    parameter int MAXREG = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_dest,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic              hold,
    output logic [NREQ-1:0]   gnt,
    output logic              wrReg,
    output logic [AW-1:0]     destReg,
    output logic [DW-1:0]     wrData,
    output logic              err_dest,
    output logic [7:0]        err_count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW-1:0] MaxDest = AW'(MAXREG);

    function automatic logic [PW-1:0] wrapIdx(input int v);
        return PW'(v % NREQ);
    endfunction

    logic [PW-1:0] ptr;
    logic [PW-1:0] gntIdx;
    logic          found;
    logic [AW-1:0] selDest;
    logic [DW-1:0] selData;

    // Search from ptr upward with wraparound; reset and hold suppress all grants.
    always_comb begin
        found  = 1'b0;
        gntIdx = '0;
        if (!rst && !hold) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req_valid[wrapIdx(int'(ptr) + k)]) begin
                    found  = 1'b1;
                    gntIdx = wrapIdx(int'(ptr) + k);
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (found) begin
            gnt[gntIdx] = 1'b1;
        end
    end

    assign selDest = req_dest[int'(gntIdx)*AW +: AW];
    assign selData = req_data[int'(gntIdx)*DW +: DW];

    // R0 requests are consumed silently; out-of-range ones are consumed and counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            wrReg     <= 1'b0;
            destReg   <= '0;
            wrData    <= '0;
            err_dest  <= 1'b0;
            err_count <= '0;
        end else begin
            wrReg    <= 1'b0;
            err_dest <= 1'b0;
            if (found) begin
                ptr <= wrapIdx(int'(gntIdx) + 1);
                if (selDest == '0) begin
                    destReg <= '0;
                end else if (selDest > MaxDest) begin
                    err_dest <= 1'b1;
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end else begin
                    wrReg   <= 1'b1;
                    destReg <= selDest;
                    wrData  <= selData;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Scoreboard bench for reg_wr_arbiter: the driver queues expected output-stage
// events, and a negedge monitor pops and compares whenever wrReg or err_dest is seen.
module tb_reg_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [14:0] req_dest;
    logic [95:0] req_data;
    logic        hold;
    logic [2:0]  gnt;
    logic        wrReg;
    logic [4:0]  destReg;
    logic [31:0] wrData;
    logic        err_dest;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [4:0]  dest;
        logic [31:0] data;
        logic        err;
        logic [7:0]  cnt;
    } outExp_t;

    outExp_t expQ[$];

    reg_wr_arbiter #(.NREQ(3), .AW(5), .DW(32), .MAXREG(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_dest(req_dest),
        .req_data(req_data), .hold(hold), .gnt(gnt), .wrReg(wrReg),
        .destReg(destReg), .wrData(wrData), .err_dest(err_dest),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setReq(input int i, input logic [4:0] d, input logic [31:0] v);
        req_dest[i*5 +: 5]  = d;
        req_data[i*32 +: 32] = v;
    endtask

    // One cycle of stimulus: check the combinational grant, queue the output event it should cause.
    task automatic applyStimulus(input logic [2:0] v, input logic h, input logic [2:0] expGnt,
                                 input logic push, input logic expWr, input logic [4:0] expDest,
                                 input logic [31:0] expData, input logic expErr, input logic [7:0] expCnt);
        outExp_t e;
        @(posedge clk);
        #1;
        req_valid = v;
        hold      = h;
        #3;
        checkOutput("gnt", 32'(gnt), 32'(expGnt));
        if (push) begin
            e.wr   = expWr;
            e.dest = expDest;
            e.data = expData;
            e.err  = expErr;
            e.cnt  = expCnt;
            expQ.push_back(e);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_wrReg"}, 32'(wrReg), 32'd0);
        checkOutput({tag, "_destReg"}, 32'(destReg), 32'd0);
        checkOutput({tag, "_wrData"}, wrData, 32'd0);
        checkOutput({tag, "_err_dest"}, 32'(err_dest), 32'd0);
        checkOutput({tag, "_err_count"}, 32'(err_count), 32'd0);
        checkOutput({tag, "_gnt"}, 32'(gnt), 32'd0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        rst       = 1'b1;
        req_valid = 3'b000;
        hold      = 1'b0;
        #1;
        checkResetState("rst_mid");
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        outExp_t e;
        if (!rst && (wrReg || err_dest)) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got wrReg=%0b err_dest=%0b dest=%0d, expected no output at %0t",
                         wrReg, err_dest, destReg, $time);
            end else begin
                e = expQ.pop_front();
                checkOutput("wrReg", 32'(wrReg), 32'(e.wr));
                checkOutput("destReg", 32'(destReg), 32'(e.dest));
                checkOutput("wrData", wrData, e.data);
                checkOutput("err_dest", 32'(err_dest), 32'(e.err));
                checkOutput("err_count", 32'(err_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        hold      = 1'b0;
        req_valid = 3'b111;
        req_dest  = '0;
        req_data  = '0;
        #2;
        checkResetState("rst_init");
        req_valid = 3'b000;
        @(negedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] single write from requester 0");
        setReq(0, 5'd5, 32'hDEADBEEF);
        applyStimulus(3'b001, 1'b0, 3'b001, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 8'd0);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 8'd0);
        doReset();

        $display("[TB] round robin over all three requesters");
        setReq(0, 5'd1, 32'hA1);
        setReq(1, 5'd2, 32'hA2);
        setReq(2, 5'd3, 32'hA3);
        for (int r = 0; r < 2; r++) begin
            applyStimulus(3'b111, 1'b0, 3'b001, 1'b1, 1'b1, 5'd1, 32'hA1, 1'b0, 8'd0);
            applyStimulus(3'b111, 1'b0, 3'b010, 1'b1, 1'b1, 5'd2, 32'hA2, 1'b0, 8'd0);
            applyStimulus(3'b111, 1'b0, 3'b100, 1'b1, 1'b1, 5'd3, 32'hA3, 1'b0, 8'd0);
        end
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 8'd0);

        $display("[TB] same destination R16 from requesters 0 and 2");
        setReq(0, 5'd16, 32'h11);
        setReq(2, 5'd16, 32'h22);
        applyStimulus(3'b101, 1'b0, 3'b001, 1'b1, 1'b1, 5'd16, 32'h11, 1'b0, 8'd0);
        applyStimulus(3'b100, 1'b0, 3'b100, 1'b1, 1'b1, 5'd16, 32'h22, 1'b0, 8'd0);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 8'd0);

        $display("[TB] R0 and out-of-range destinations");
        setReq(1, 5'd0, 32'h55);
        applyStimulus(3'b010, 1'b0, 3'b010, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 8'd0);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 8'd0);
        setReq(2, 5'd17, 32'h66);
        applyStimulus(3'b100, 1'b0, 3'b100, 1'b1, 1'b0, 5'd0, 32'h22, 1'b1, 8'd1);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 8'd0);

        $display("[TB] hold blocks grants and freezes the pointer");
        setReq(0, 5'd7, 32'h70);
        setReq(1, 5'd8, 32'h80);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(3'b011, 1'b1, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 8'd1);
        end
        applyStimulus(3'b011, 1'b0, 3'b001, 1'b1, 1'b1, 5'd7, 32'h70, 1'b0, 8'd1);
        applyStimulus(3'b010, 1'b0, 3'b010, 1'b1, 1'b1, 5'd8, 32'h80, 1'b0, 8'd1);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 8'd1);

        $display("[TB] write in output stage commits under hold");
        setReq(0, 5'd9, 32'h90);
        applyStimulus(3'b001, 1'b0, 3'b001, 1'b1, 1'b1, 5'd9, 32'h90, 1'b0, 8'd1);
        applyStimulus(3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 8'd1);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 8'd1);

        $display("[TB] reset discards a pending write");
        setReq(0, 5'd10, 32'hAA);
        applyStimulus(3'b001, 1'b0, 3'b001, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 8'd0);
        doReset();
        setReq(2, 5'd4, 32'h44);
        applyStimulus(3'b100, 1'b0, 3'b100, 1'b1, 1'b1, 5'd4, 32'h44, 1'b0, 8'd0);
        applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 8'd0);

        repeat (3) @(negedge clk);
        #1;
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
